// File: rtl/rs232_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rs232_tx_arbiter_pkg
// Purpose : Shared definitions for the RS232 transmit arbiter: FSM state
//           encoding, default header base and the header-byte helper.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package rs232_tx_arbiter_pkg;

  // Width of a requester index; supports up to 8 requesters.
  localparam int GRANT_W = 3;

  // Default header base; the granted index is ORed into bits [2:0].
  localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_FORWARD = 2'd2
  } state_e;

  function automatic logic [7:0] header_byte(input logic [7:0]         base,
                                             input logic [GRANT_W-1:0] idx);
    return base | {5'b0, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_tx_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module  : rr_select
// Purpose : Round-robin requester selector. Finds the first set request bit
//           starting at last_grant+1 and wrapping around.
// Ports   : req_i        - request vector, one bit per requester
//           last_grant_i - index of the previously granted requester
//           next_grant_o - selected index (last_grant_i when nothing set)
//           any_o        - at least one request bit is set
// Rev     : 1.0 - initial release
// ============================================================================
module rr_select
  import rs232_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [GRANT_W-1:0]   last_grant_i,
  output logic [GRANT_W-1:0]   next_grant_o,
  output logic                 any_o
);

  logic [2*NUM_PORTS-1:0] req2;
  logic [NUM_PORTS-1:0]   rot;
  logic                   found;
  int                     idx;

  always_comb begin
    // Rotate so that bit 0 of rot is requester last_grant+1.
    req2         = {req_i, req_i};
    rot          = NUM_PORTS'(req2 >> (int'(last_grant_i) + 1));
    next_grant_o = last_grant_i;
    found        = 1'b0;
    idx          = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = int'(last_grant_i) + 1 + k;
        if (idx >= NUM_PORTS) begin
          idx = idx - NUM_PORTS;
        end
        next_grant_o = GRANT_W'(idx);
      end
    end
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/rs232_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rs232_tx_arbiter
// Purpose : Arbitrates byte packets from NUM_PORTS requesters onto a single
//           RS232 transmit stream. Each packet is prefixed by a header byte
//           (HEADER_BASE | index); a stalled requester loses its grant after
//           TIMEOUT idle cycles.
// Ports   : clock, reset          - clock, async active-high reset
//           req_data/valid/last   - per-requester byte stream (in)
//           req_ready             - per-requester byte accepted (out)
//           odata/ovalid/oready   - registered byte stream to transmitter
//           grant                 - current / most recent granted index
//           timeout_flag          - sticky, set on a timeout revocation
// Rev     : 1.0 - initial release
// ============================================================================
module rs232_tx_arbiter
  import rs232_tx_arbiter_pkg::*;
#(
  parameter int         NUM_PORTS   = 4,
  parameter logic [7:0] HEADER_BASE = HEADER_BASE_DEFAULT,
  parameter int         TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_PORTS*8-1:0] req_data,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [NUM_PORTS-1:0]   req_last,
  output logic [NUM_PORTS-1:0]   req_ready,
  output logic [7:0]             odata,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [GRANT_W-1:0]     grant,
  output logic                   timeout_flag
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e               state_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [7:0]           odata_q;
  logic                 ovalid_q;
  logic [CNT_W-1:0]     idle_cnt_q;
  logic                 timeout_flag_q;

  logic [GRANT_W-1:0]   grant_d;
  logic                 any_req;
  logic [NUM_PORTS-1:0] gnt_oh;
  logic [7:0]           sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 out_free;
  logic                 accept;

  rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_select (
    .req_i        (req_valid),
    .last_grant_i (grant_q),
    .next_grant_o (grant_d),
    .any_o        (any_req)
  );

  // One-hot decode of the grant plus the granted requester's byte.
  always_comb begin
    gnt_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        gnt_oh[i] = 1'b1;
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // The output register can take a byte when empty or draining this cycle.
  assign out_free  = !ovalid_q || oready;
  assign sel_valid = |(req_valid & gnt_oh);
  assign sel_last  = |(req_last & gnt_oh);
  assign req_ready = (state_q == ST_FORWARD && out_free) ? gnt_oh : '0;
  assign accept    = (state_q == ST_FORWARD) && out_free && sel_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= GRANT_W'(NUM_PORTS - 1);
      odata_q        <= '0;
      ovalid_q       <= 1'b0;
      idle_cnt_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      // Downstream handshake empties the output register; a load later in
      // this block overrides it.
      if (ovalid_q && oready) begin
        ovalid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          // Arbitrate only once the previous packet has fully drained.
          if (!ovalid_q && any_req) begin
            grant_q <= grant_d;
            state_q <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (out_free) begin
            odata_q    <= header_byte(HEADER_BASE, grant_q);
            ovalid_q   <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (accept) begin
            odata_q    <= sel_data;
            ovalid_q   <= 1'b1;
            idle_cnt_q <= '0;
            if (sel_last) begin
              state_q <= ST_IDLE;
            end
          end else if (idle_cnt_q == CNT_LAST) begin
            // Revoke the grant; a pending output byte still drains in IDLE.
            idle_cnt_q     <= '0;
            timeout_flag_q <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign odata        = odata_q;
  assign ovalid       = ovalid_q;
  assign grant        = grant_q;
  assign timeout_flag = timeout_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_rs232_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs232_tx_arbiter
// Purpose : Directed self-checking bench for rs232_tx_arbiter (4 ports,
//           header base A0, timeout 1024).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_rs232_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  odata;
  logic        ovalid;
  logic        oready;
  logic [2:0]  grant;
  logic        timeout_flag;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_g [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

  always #5 clock = ~clock;

  rs232_tx_arbiter #(
    .NUM_PORTS   (4),
    .HEADER_BASE (8'hA0),
    .TIMEOUT     (1024)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .odata        (odata),
    .ovalid       (ovalid),
    .oready       (oready),
    .grant        (grant),
    .timeout_flag (timeout_flag)
  );

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    oready    = 1'b1;
    #1;
    chk("rst_ovalid", ovalid, 0);
    chk("rst_grant", grant, 3);
    chk("rst_tflag", timeout_flag, 0);
    chk("rst_ready", req_ready, 0);
    tick();
    tick();
    reset = 1'b0;

    // Port 2 packet 11,22,33 with oready held high
    req_data  = 32'h0011_0000;
    req_valid = 4'b0100;
    tick(); chk("a_grant", grant, 2); chk("a_hdr_ready", req_ready, 0); chk("a_hdr_ovalid", ovalid, 0);
    tick(); chk("a_hdr", odata, 8'hA2); chk("a_hdr_v", ovalid, 1); chk("a_ready1", req_ready, 4'b0100);
    tick(); chk("a_b11", odata, 8'h11); chk("a_ready2", req_ready, 4'b0100);
    req_data = 32'h0022_0000;
    tick(); chk("a_b22", odata, 8'h22);
    req_data = 32'h0033_0000;
    req_last = 4'b0100;
    #1; chk("a_ready3", req_ready, 4'b0100);
    tick(); chk("a_b33", odata, 8'h33); chk("a_b33_v", ovalid, 1); chk("a_idle_ready", req_ready, 0);
    req_valid = '0;
    req_last  = '0;
    tick(); chk("a_drain", ovalid, 0);

    // Port 1 packet with 5 cycles of downstream backpressure
    req_data  = 32'h0000_5100;
    req_valid = 4'b0010;
    tick(); chk("b_grant", grant, 1);
    tick(); chk("b_hdr", odata, 8'hA1);
    tick(); chk("b_b51", odata, 8'h51);
    oready   = 1'b0;
    req_data = 32'h0000_5200;
    #1; chk("b_stall_ready0", req_ready, 0);
    repeat (5) begin
      tick();
      chk("b_hold_data", odata, 8'h51);
      chk("b_hold_valid", ovalid, 1);
      chk("b_hold_ready", req_ready, 0);
    end
    oready = 1'b1;
    #1; chk("b_resume_ready", req_ready, 4'b0010);
    tick(); chk("b_b52", odata, 8'h52);
    req_data = 32'h0000_5300;
    tick(); chk("b_b53", odata, 8'h53);
    req_data = 32'h0000_5400;
    req_last = 4'b0010;
    tick(); chk("b_b54", odata, 8'h54);
    req_valid = '0;
    req_last  = '0;
    tick(); chk("b_drain", ovalid, 0);

    // From reset, ports 0 and 1 each with a 1-byte packet
    pulse_reset();
    req_data  = 32'h0000_2010;
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    tick(); chk("c_grant0", grant, 0);
    tick(); chk("c_hdr0", odata, 8'hA0); chk("c_ready0", req_ready, 4'b0001);
    tick(); chk("c_b10", odata, 8'h10);
    req_valid = 4'b0010;
    tick(); chk("c_drain0", ovalid, 0); chk("c_hold_grant", grant, 0);
    tick(); chk("c_grant1", grant, 1);
    tick(); chk("c_hdr1", odata, 8'hA1);
    tick(); chk("c_b20", odata, 8'h20);
    req_valid = '0;
    req_last  = '0;
    tick(); chk("c_drain1", ovalid, 0);

    // All four ports continuously valid: grants 0,1,2,3,0
    pulse_reset();
    req_data  = 32'hC3C2_C1C0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(); chk("d_grant", grant, exp_g[k]);
      tick(); chk("d_hdr", odata, 8'hA0 | exp_g[k]);
      tick(); chk("d_byte", odata, 8'hC0 | exp_g[k]);
      tick(); chk("d_drain", ovalid, 0);
    end
    req_valid = '0;
    req_last  = '0;

    // Port 3 sends one byte then stalls: timeout after 1024 idle cycles
    pulse_reset();
    req_data  = 32'h7700_0000;
    req_valid = 4'b1000;
    tick(); chk("e_grant3", grant, 3);
    tick(); chk("e_hdr", odata, 8'hA3);
    tick(); chk("e_b77", odata, 8'h77);
    req_valid = '0;
    repeat (1023) tick();
    chk("e_tflag_pre", timeout_flag, 0);
    chk("e_still_fwd", req_ready, 4'b1000);
    tick();
    chk("e_tflag", timeout_flag, 1);
    chk("e_idle_ready", req_ready, 0);
    req_data  = 32'h0002_0001;
    req_valid = 4'b0101;
    req_last  = 4'b0101;
    tick(); chk("e_next_grant", grant, 0);
    tick(); chk("e_next_hdr", odata, 8'hA0);
    tick(); chk("e_next_byte", odata, 8'h01);
    req_valid = '0;
    req_last  = '0;
    tick(); chk("e_drain", ovalid, 0); chk("e_sticky", timeout_flag, 1);

    // Reset asserted mid-FORWARD
    req_data  = 32'h0000_9900;
    req_valid = 4'b0010;
    tick(); chk("f_grant", grant, 1);
    tick(); chk("f_hdr", odata, 8'hA1);
    tick(); chk("f_b99", odata, 8'h99); chk("f_b99_v", ovalid, 1);
    reset    = 1'b1;
    req_last = 4'b0010;
    #1;
    chk("f_async_ovalid", ovalid, 0);
    chk("f_async_grant", grant, 3);
    chk("f_async_tflag", timeout_flag, 0);
    chk("f_async_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    tick(); chk("f_regrant", grant, 1); chk("f_regrant_ov", ovalid, 0);
    tick(); chk("f_rehdr", odata, 8'hA1); chk("f_rehdr_v", ovalid, 1);
    tick(); chk("f_reb99", odata, 8'h99);

    // Port 2 valid only during the drain cycle must not be granted
    req_data  = 32'h3322_9900;
    req_valid = 4'b0100;
    req_last  = 4'b1100;
    tick(); chk("g_drain", ovalid, 0); chk("g_no_arb", grant, 1);
    req_valid = 4'b1000;
    tick(); chk("g_grant3", grant, 3);
    tick(); chk("g_hdr", odata, 8'hA3);
    tick(); chk("g_b33", odata, 8'h33);
    req_valid = '0;
    req_last  = '0;
    tick(); chk("g_end", ovalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
